// File: rtl/intc_prio.sv
// intc_prio: four-source fixed-priority interrupt controller.
// Synchronises and edge-detects the request lines, holds the pending and
// mask registers, picks the lowest-index enabled request, and tracks the
// request / in-service handshake with the CPU. Nesting is not supported.
module intc_prio #(
  parameter int                NSRC       = 4,
  parameter int                VEC_W      = 10,
  parameter logic [VEC_W-1:0]  VEC_BASE   = 10'h3F0,
  parameter int                VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_in,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_in,
  input  logic             cpu_ack,
  input  logic             cpu_reti,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [1:0]       irq_id,
  output logic [NSRC-1:0]  pending,
  output logic [NSRC-1:0]  mask,
  output logic             in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [VEC_W-1:0] STRIDE_V = VEC_W'(VEC_STRIDE);

  state_t            state_q, state_d;
  logic [NSRC-1:0]   s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [1:0]        irq_id_q, irq_id_d;
  logic [VEC_W-1:0]  irq_vec_q, irq_vec_d;

  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   cand;
  logic [NSRC-1:0]   clr;
  logic              win_valid;
  logic [1:0]        win_id;
  logic [VEC_W-1:0]  vec_calc;

  // Three-stage chain: s1/s2 resynchronise, s3 remembers the previous s2.
  // s3 resets to 0, so a line already high at reset release yields one edge.
  always_comb begin
    s1_d = irq_in;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
  end

  // Fixed-priority pick among enabled pending requests; lowest index wins.
  always_comb begin
    cand      = pending_q & mask_q;
    win_valid = |cand;
    win_id    = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) win_id = 2'(i);
    end
    // Vector wraps modulo 2^VEC_W by construction of the operand widths.
    vec_calc = VEC_BASE + STRIDE_V * VEC_W'(win_id);
  end

  // Handshake FSM: latch winner on IDLE->REQ, clear it on ack, release on reti.
  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    irq_vec_d = irq_vec_q;
    clr       = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = REQ;
          irq_id_d  = win_id;
          irq_vec_d = vec_calc;
        end
      end
      REQ: begin
        // Ack has precedence over a withdrawal caused by the mask.
        if (cpu_ack) begin
          clr[irq_id_q] = 1'b1;
          state_d       = SERVICE;
        end else if (!mask_q[irq_id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (cpu_reti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending bits: a fresh edge in the same cycle as the ack clear survives.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_in : mask_q;
  end

  // State register with asynchronous active-low clear of everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_id_q  <= '0;
      irq_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_id_q  <= irq_id_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = irq_id_q;
  assign irq_vec    = irq_vec_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: doc/intc_prio.md
Name: intc_prio

Overview:
Priority interrupt controller for the monocycle CPU. It latches edge-triggered requests from up to four external sources, masks them, and picks one winner by fixed priority. It then presents a request plus a 10-bit PC vector to the control unit and tracks the in-service period until return-from-interrupt. Only one interrupt is serviced at a time; nesting is not supported.

Parameters:
NSRC, 4, number of interrupt sources (arbitration logic is sized for 4; only 4 is supported).
VEC_W, 10, vector width; matches the PC width.
VEC_BASE, 10'h3F0, vector of source 0.
VEC_STRIDE, 4, address distance between consecutive source vectors.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
irq_in  in  NSRC  asynchronous interrupt lines; a rising edge raises a request.
mask_we  in  1  loads mask_in into the mask register at the clock edge.
mask_in  in  NSRC  new mask value; 1 = source enabled.
cpu_ack  in  1  one-cycle pulse: the CPU has saved the PC and jumped to irq_vec.
cpu_reti  in  1  one-cycle pulse: the CPU executed return-from-interrupt.
irq_req  out  1  interrupt request to the control unit.
irq_vec  out  VEC_W  target PC; valid while irq_req=1.
irq_id  out  2  index of the winning source.
pending  out  NSRC  latched pending bits.
mask  out  NSRC  current mask register.
in_service  out  1  high from ack until reti.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - state=IDLE; sync flops, pending, mask, irq_id and irq_vec all 0.
  - irq_req=0, in_service=0.
- Synchronizer and edge detect, per source:
  - Chain s1 -> s2 -> s3.
  - pending[i] is set at an edge where s2=1 and s3=0.
  - irq_in rising before edge k gives pending=1 after edge k+2.
  - A level already high at reset release counts as one edge.
  - A pulse shorter than one clock may be lost.
- Mask:
  - Registered; loads on mask_we.
  - Arbitration uses the registered value, so a write affects arbitration from the following cycle.
  - Pending bits of masked sources are retained, not cleared.
- Arbitration:
  - Candidates are pending & mask.
  - Lowest index wins (source 0 has highest priority).
  - Combinational within IDLE; result registered on entry to REQ.
- Vector arithmetic:
  - irq_vec = VEC_BASE + irq_id*VEC_STRIDE, truncated to VEC_W bits (wraps modulo 2^VEC_W).
- FSM state IDLE:
  - irq_req=0, in_service=0.
  - If any candidate: register irq_id and irq_vec, go to REQ.
- FSM state REQ:
  - irq_req=1; irq_id and irq_vec stay stable.
  - cpu_ack: clear pending[irq_id], go to SERVICE (irq_req=0 the next cycle).
  - Winner's mask bit becomes 0 without ack: withdraw, back to IDLE, irq_req drops after that edge.
  - Ack and mask-clear in the same cycle: ack wins.
  - Higher-priority source arriving during REQ: no preemption; the latched winner is kept.
- FSM state SERVICE:
  - in_service=1, irq_req=0.
  - Pending bits keep accumulating.
  - cpu_reti: go to IDLE; the next arbitration happens in the following cycle, so irq_req is earliest 2 edges after the reti edge.
- Simultaneous events:
  - New edge on source i in the same cycle its pending is cleared by ack: pending[i] stays 1.
  - cpu_ack outside REQ is ignored.
  - cpu_reti outside SERVICE is ignored.
  - cpu_ack and cpu_reti together in REQ: treat as ack only.
- Reset mid-operation: immediately returns to the reset state from any FSM state; all pending requests are lost.
- Latency: idle controller, enabled source, edge before edge k -> pending after k+2, irq_req=1 after k+3.

Test Plan:
1. Reset, mask_we with mask_in=4'b0100, pulse irq_in[2] -> pending=4'b0100 after 3 edges, irq_req=1 after 4 edges, irq_id=2, irq_vec=10'h3F8; cpu_ack -> pending=0, in_service=1; cpu_reti -> in_service=0, irq_req stays 0.
2. mask=4'b1111, raise irq_in[3] and irq_in[1] in the same cycle -> irq_id=1, vec=10'h3F4; ack, reti -> irq_id=3, vec=10'h3FC.
3. mask=0, pulse irq_in[0] -> pending=4'b0001, irq_req stays 0; then write mask=4'b0001 -> irq_req=1 two edges after the write, vec=10'h3F0.
4. In REQ for source 2, write mask=0 without ack -> irq_req=0, state IDLE, pending[2] still 1.
5. During SERVICE of source 0, raise irq_in[0] again -> pending[0]=1, irq_req=0 until cpu_reti, then irq_req=1 with vec=10'h3F0.
6. VEC_BASE=10'h3FC, source 1 -> irq_vec=10'h000 (wrap); assert reset=0 while in REQ -> irq_req=0, pending=0, mask=0 at once.
